multi_target_game_logic: RTL and testbench
==========================================

# multi_target_game_logic

Parametrised shooting-game controller for the Duck Hunt game-control path: decodes mouse clicks into shots against N on-screen targets, manages magazine/reserve ammunition with timed reloads, score, countdown/fall delays and game-over. Sits between the mouse interface and the target (duck) and dog animation controllers. It is the multi-target successor of the single-duck game logic.

## Interface
- N_TARGETS, 2: number of independent targets.
- MAG_SIZE, 3: magazine capacity.
- RESERVE, 15: initial reserve rounds.
- TARGET_W, 96 / TARGET_H, 60: hit-box size in pixels.
- SCORE_W, 7: score width.
- COUNTDOWN_CYC, 7500*65_000: start/restart delay in clock cycles.
- DEATH_CYC, 4500*65_000: fall time after a kill.
- DOG_AT_CYC, 2500*65_000: remaining-fall-time value that triggers the dog.
- RELOAD_CYC, 500*65_000: reload duration.
- clk  in  1  posedge clock.
- rst_n  in  1  asynchronous active-low reset.
- mouse_xpos, mouse_ypos  in  12 each  cursor position.
- left_mouse, right_mouse  in  1 each  raw button levels.
- game_enable  in  1  level; game runs while high.
- target_xpos, target_ypos  in  12*N_TARGETS each  packed top-left corners, target i at bits [12i+11:12i].
- target_alive  in  N_TARGETS  target i currently shootable.
- bullets_in_magazine  out  $clog2(MAG_SIZE+1).
- bullets_left  out  $clog2(RESERVE+1)  reserve count.
- my_score  out  SCORE_W.
- hunt_start  out  1  high in HUNTING and RELOADING.
- show_reload_char  out  1  magazine empty.
- target_killed  out  N_TARGETS  one-cycle one-hot kill pulse.
- dog_bird_enable  out  1  one-cycle pulse.
- game_over  out  1  level.

## Operation
- States: IDLE, COUNTDOWN, HUNTING, RELOADING, FALLING, GAME_OVER; one down-counter `timer` shared by COUNTDOWN/RELOADING/FALLING.
- Button edges: registered previous levels; edge = level & ~prev.
- IDLE: ammo = MAG_SIZE/RESERVE, score 0. game_enable high -> COUNTDOWN, timer = COUNTDOWN_CYC-1.
- COUNTDOWN: timer decrements; clicks ignored; timer==0 -> HUNTING.
- HUNTING, left edge, magazine>0: magazine-1. Hit = lowest index i with target_alive[i] and xpos_i <= mouse_x <= xpos_i+TARGET_W, ypos_i <= mouse_y <= ypos_i+TARGET_H (inclusive, 13-bit sums, no wrap). Hit -> target_killed[i] pulse, score+1 (saturating at 2^SCORE_W-1), FALLING, timer = DEATH_CYC-1. Max one kill per shot. Left edge with magazine 0: no effect.
- HUNTING, right edge, magazine<MAG_SIZE and reserve>0 -> RELOADING, timer = RELOAD_CYC-1; otherwise ignored. Left and right edges same cycle: left wins, right dropped.
- RELOADING: clicks ignored; timer==0: moved = min(MAG_SIZE-magazine, reserve); magazine+=moved, reserve-=moved; -> HUNTING.
- FALLING: clicks ignored; dog_bird_enable pulses the cycle timer==DOG_AT_CYC; timer==0 -> HUNTING.
- HUNTING with magazine==0 and reserve==0 -> GAME_OVER. GAME_OVER: game_over=1, hunt_start=0; leaves only via game_enable low.
- game_enable low in any state -> IDLE next cycle (abort, ammo/score restored at IDLE entry).

## Timing
- Reset: state IDLE, bullets_in_magazine=MAG_SIZE, bullets_left=RESERVE, my_score=0, hunt_start=0, show_reload_char=0, target_killed=0, dog_bird_enable=0, game_over=0, timer=0.
- All outputs registered. Edge sampled in cycle t (left_mouse high at t, low at t-1) -> magazine, score, target_killed updated at edge t+1.
- Timer loaded with X-1 runs exactly X cycles in its state.
- show_reload_char follows the registered magazine value, same cycle.

## Configuration
- AUTO_RELOAD_EN defined: a shot that leaves magazine 0 with reserve>0 enters RELOADING directly when no kill occurs (kill: FALLING first, then RELOADING automatically on exit instead of HUNTING).
- Undefined: reload only by right-click edge.

## Structure
- Shared package game_pkg: state enum typedef, default timing constants (cycle counts at 65 MHz), coordinate width 12.
- Sub-module target_hit_detect: combinational parametrised priority hit test over N_TARGETS, outputs hit and one-hot index.

## Test plan
Use COUNTDOWN_CYC=40, DEATH_CYC=20, DOG_AT_CYC=8, RELOAD_CYC=4, N_TARGETS=2.
- Release reset, game_enable=1 -> hunt_start rises 41 cycles after enable; clicks during countdown leave magazine 3.
- Targets 0 and 1 overlap at (100,100), both alive, click at (150,130) -> target_killed=2'b01 one cycle, score 1, magazine 2, dog pulse after 11 FALLING cycles, HUNTING after 20.
- Click at (196,160) (exact corner) hits; (197,160) misses, magazine still decrements.
- Magazine 1, reserve 1, right edge -> after 4 cycles magazine 2, reserve 0; further right edge ignored.
- Fire all 18 rounds with misses and reloads -> game_over=1; game_enable low -> IDLE, magazine 3, reserve 15, score 0.
- AUTO_RELOAD_EN build: third miss -> RELOADING without right-click, magazine 3, reserve 12.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and default timing for the Duck Hunt game-control path.
// Cycle counts assume a 65 MHz clock.
package game_pkg;

  localparam int COORD_W = 12;

  localparam int DEF_COUNTDOWN_CYC = 7500 * 65_000;
  localparam int DEF_DEATH_CYC     = 4500 * 65_000;
  localparam int DEF_DOG_AT_CYC    = 2500 * 65_000;
  localparam int DEF_RELOAD_CYC    = 500 * 65_000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNTDOWN,
    S_HUNTING,
    S_RELOADING,
    S_FALLING,
    S_GAME_OVER
  } state_t;

  // Inclusive span test; the 13-bit sum keeps a box near the right/bottom edge from wrapping.
  function automatic logic in_span(input logic [COORD_W-1:0] pos,
                                   input logic [COORD_W-1:0] origin,
                                   input int size);
    logic [COORD_W:0] lo;
    logic [COORD_W:0] hi;
    lo = {1'b0, origin};
    hi = lo + (COORD_W+1)'(size);
    return ({1'b0, pos} >= lo) && ({1'b0, pos} <= hi);
  endfunction

endpackage

// File: rtl/target_hit_detect.sv
// Combinational priority hit test: the lowest-index live target under the cursor wins.
module target_hit_detect
  import game_pkg::*;
#(
  parameter int N_TARGETS = 2,
  parameter int TARGET_W  = 96,
  parameter int TARGET_H  = 60
) (
  input  logic [COORD_W-1:0]           mouse_x_i,
  input  logic [COORD_W-1:0]           mouse_y_i,
  input  logic [COORD_W*N_TARGETS-1:0] target_x_i,
  input  logic [COORD_W*N_TARGETS-1:0] target_y_i,
  input  logic [N_TARGETS-1:0]         target_alive_i,
  output logic                         hit_o,
  output logic [N_TARGETS-1:0]         hit_onehot_o
);

  always_comb begin
    hit_o        = 1'b0;
    hit_onehot_o = '0;
    for (int i = 0; i < N_TARGETS; i++) begin
      if (!hit_o && target_alive_i[i]
          && in_span(mouse_x_i, target_x_i[COORD_W*i +: COORD_W], TARGET_W)
          && in_span(mouse_y_i, target_y_i[COORD_W*i +: COORD_W], TARGET_H)) begin
        hit_o           = 1'b1;
        hit_onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_target_game_logic.sv
// Multi-target Duck Hunt game controller: shots, ammo, reloads, score, fall timing, game-over.
// Optional: define AUTO_RELOAD_EN to reload automatically when a shot empties the magazine.
module multi_target_game_logic
  import game_pkg::*;
#(
  parameter int N_TARGETS     = 2,
  parameter int MAG_SIZE      = 3,
  parameter int RESERVE       = 15,
  parameter int TARGET_W      = 96,
  parameter int TARGET_H      = 60,
  parameter int SCORE_W       = 7,
  parameter int COUNTDOWN_CYC = DEF_COUNTDOWN_CYC,
  parameter int DEATH_CYC     = DEF_DEATH_CYC,
  parameter int DOG_AT_CYC    = DEF_DOG_AT_CYC,
  parameter int RELOAD_CYC    = DEF_RELOAD_CYC
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [11:0]                     mouse_xpos,
  input  logic [11:0]                     mouse_ypos,
  input  logic                            left_mouse,
  input  logic                            right_mouse,
  input  logic                            game_enable,
  input  logic [12*N_TARGETS-1:0]         target_xpos,
  input  logic [12*N_TARGETS-1:0]         target_ypos,
  input  logic [N_TARGETS-1:0]            target_alive,
  output logic [$clog2(MAG_SIZE+1)-1:0]   bullets_in_magazine,
  output logic [$clog2(RESERVE+1)-1:0]    bullets_left,
  output logic [SCORE_W-1:0]              my_score,
  output logic                            hunt_start,
  output logic                            show_reload_char,
  output logic [N_TARGETS-1:0]            target_killed,
  output logic                            dog_bird_enable,
  output logic                            game_over
);

  localparam int MAG_W = $clog2(MAG_SIZE+1);
  localparam int RES_W = $clog2(RESERVE+1);

  state_t               state_q, state_d;
  logic [31:0]          timer_q, timer_d;
  logic [MAG_W-1:0]     mag_q, mag_d;
  logic [RES_W-1:0]     res_q, res_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [N_TARGETS-1:0] killed_q, killed_d;
  logic                 dog_q, dog_d;
  logic                 hunt_q, hunt_d;
  logic                 over_q, over_d;
  logic                 leftPrev_q, rightPrev_q;

  logic                 leftEdge, rightEdge;
  logic                 hitAny;
  logic [N_TARGETS-1:0] hitOneHot;
  int                   room, moved;

  assign leftEdge  = left_mouse & ~leftPrev_q;
  assign rightEdge = right_mouse & ~rightPrev_q;

  target_hit_detect #(
    .N_TARGETS(N_TARGETS),
    .TARGET_W (TARGET_W),
    .TARGET_H (TARGET_H)
  ) u_hit (
    .mouse_x_i     (mouse_xpos),
    .mouse_y_i     (mouse_ypos),
    .target_x_i    (target_xpos),
    .target_y_i    (target_ypos),
    .target_alive_i(target_alive),
    .hit_o         (hitAny),
    .hit_onehot_o  (hitOneHot)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    mag_d    = mag_q;
    res_d    = res_q;
    score_d  = score_q;
    killed_d = '0;
    room     = MAG_SIZE - int'(mag_q);
    moved    = (room < int'(res_q)) ? room : int'(res_q);

    case (state_q)
      S_IDLE: begin
        if (game_enable) begin
          state_d = S_COUNTDOWN;
          timer_d = 32'(COUNTDOWN_CYC - 1);
        end
      end
      S_COUNTDOWN: begin
        if (timer_q == '0) state_d = S_HUNTING;
        else               timer_d = timer_q - 32'd1;
      end
      S_HUNTING: begin
        if (mag_q == '0 && res_q == '0) begin
          state_d = S_GAME_OVER;
        end else if (leftEdge) begin
          // A left edge always swallows a simultaneous right edge, even when the magazine is dry.
          if (mag_q != '0) begin
            mag_d = mag_q - MAG_W'(1);
            if (hitAny) begin
              killed_d = hitOneHot;
              if (score_q != '1) score_d = score_q + SCORE_W'(1);
              state_d = S_FALLING;
              timer_d = 32'(DEATH_CYC - 1);
            end
`ifdef AUTO_RELOAD_EN
            else if (mag_q == MAG_W'(1) && res_q != '0) begin
              state_d = S_RELOADING;
              timer_d = 32'(RELOAD_CYC - 1);
            end
`endif
          end
        end else if (rightEdge && mag_q < MAG_W'(MAG_SIZE) && res_q != '0) begin
          state_d = S_RELOADING;
          timer_d = 32'(RELOAD_CYC - 1);
        end
      end
      S_RELOADING: begin
        if (timer_q == '0) begin
          mag_d   = MAG_W'(int'(mag_q) + moved);
          res_d   = RES_W'(int'(res_q) - moved);
          state_d = S_HUNTING;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      S_FALLING: begin
        if (timer_q == '0) begin
          state_d = S_HUNTING;
`ifdef AUTO_RELOAD_EN
          if (mag_q == '0 && res_q != '0) begin
            state_d = S_RELOADING;
            timer_d = 32'(RELOAD_CYC - 1);
          end
`endif
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      S_GAME_OVER: state_d = S_GAME_OVER;
      default:     state_d = S_IDLE;
    endcase

    if (!game_enable) state_d = S_IDLE;

    // Ammo and score are restored on the way into IDLE so an abort is visible next cycle.
    if (state_d == S_IDLE) begin
      mag_d    = MAG_W'(MAG_SIZE);
      res_d    = RES_W'(RESERVE);
      score_d  = '0;
      timer_d  = '0;
      killed_d = '0;
    end

    hunt_d = (state_d == S_HUNTING) || (state_d == S_RELOADING);
    over_d = (state_d == S_GAME_OVER);
    dog_d  = (state_d == S_FALLING) && (timer_d == 32'(DOG_AT_CYC));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      mag_q       <= MAG_W'(MAG_SIZE);
      res_q       <= RES_W'(RESERVE);
      score_q     <= '0;
      killed_q    <= '0;
      dog_q       <= 1'b0;
      hunt_q      <= 1'b0;
      over_q      <= 1'b0;
      leftPrev_q  <= 1'b0;
      rightPrev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      mag_q       <= mag_d;
      res_q       <= res_d;
      score_q     <= score_d;
      killed_q    <= killed_d;
      dog_q       <= dog_d;
      hunt_q      <= hunt_d;
      over_q      <= over_d;
      leftPrev_q  <= left_mouse;
      rightPrev_q <= right_mouse;
    end
  end

  assign bullets_in_magazine = mag_q;
  assign bullets_left        = res_q;
  assign my_score            = score_q;
  assign hunt_start          = hunt_q;
  assign show_reload_char    = (mag_q == '0);
  assign target_killed       = killed_q;
  assign dog_bird_enable     = dog_q;
  assign game_over           = over_q;

endmodule

// File: tb/tb_multi_target_game_logic.sv
// Scoreboard bench for multi_target_game_logic with short timing constants.
// Build with AUTO_RELOAD_EN defined to exercise the automatic-reload variant.
module tb_multi_target_game_logic;

`ifdef AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [11:0] mouse_xpos, mouse_ypos;
  logic        left_mouse, right_mouse;
  logic        game_enable;
  logic [23:0] target_xpos, target_ypos;
  logic [1:0]  target_alive;
  logic [1:0]  bullets_in_magazine;
  logic [3:0]  bullets_left;
  logic [6:0]  my_score;
  logic        hunt_start, show_reload_char, dog_bird_enable, game_over;
  logic [1:0]  target_killed;

  multi_target_game_logic #(
    .N_TARGETS(2), .MAG_SIZE(3), .RESERVE(15), .TARGET_W(96), .TARGET_H(60), .SCORE_W(7),
    .COUNTDOWN_CYC(40), .DEATH_CYC(20), .DOG_AT_CYC(8), .RELOAD_CYC(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .left_mouse(left_mouse), .right_mouse(right_mouse),
    .game_enable(game_enable),
    .target_xpos(target_xpos), .target_ypos(target_ypos), .target_alive(target_alive),
    .bullets_in_magazine(bullets_in_magazine), .bullets_left(bullets_left),
    .my_score(my_score), .hunt_start(hunt_start), .show_reload_char(show_reload_char),
    .target_killed(target_killed), .dog_bird_enable(dog_bird_enable), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_KILL, EV_DOG, EV_HUNT} evKind_t;
  typedef struct {
    evKind_t kind;
    int      value;
  } expItem_t;

  expItem_t expQ[$];
  int tests = 0;
  int fails = 0;
  int magM  = 3;
  int resM  = 15;
  int scoreM = 0;

  function automatic int packKill(input int oneHot, input int score, input int mag);
    return (oneHot << 16) | (score << 8) | mag;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushExp(input evKind_t kind, input int value);
    expItem_t it;
    it.kind  = kind;
    it.value = value;
    expQ.push_back(it);
  endtask

  task automatic observe(input evKind_t kind, input int actual);
    expItem_t it;
    tests++;
    if (expQ.size() == 0) begin
      fails++;
      $display("[TB] FAIL unexpected_%s: got %0d expected no event", kind.name(), actual);
    end else begin
      it = expQ.pop_front();
      if (it.kind != kind || it.value != actual) begin
        fails++;
        $display("[TB] FAIL event_%s: got %s=%0d expected %s=%0d",
                 kind.name(), kind.name(), actual, it.kind.name(), it.value);
      end
    end
  endtask

  // Monitor: every kill, dog pulse and hunt_start rise is matched against the scoreboard.
  initial begin
    int  markCyc;
    logic huntPrev, enPrev;
    markCyc  = 0;
    huntPrev = 1'b0;
    enPrev   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (game_enable && !enPrev) markCyc = cyc;
        if (target_killed != '0) begin
          observe(EV_KILL, packKill(int'(target_killed), int'(my_score), int'(bullets_in_magazine)));
          markCyc = cyc;
        end
        if (dog_bird_enable) observe(EV_DOG, cyc - markCyc);
        if (hunt_start && !huntPrev) observe(EV_HUNT, cyc - markCyc);
      end
      huntPrev = hunt_start;
      enPrev   = game_enable;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int x, input int y, input logic l, input logic r);
    mouse_xpos  = 12'(x);
    mouse_ypos  = 12'(y);
    left_mouse  = l;
    right_mouse = r;
    tick(1);
    left_mouse  = 1'b0;
    right_mouse = 1'b0;
  endtask

  task automatic checkAmmo(input string name);
    checkOutput({name, ".mag"},   int'(bullets_in_magazine), magM);
    checkOutput({name, ".res"},   int'(bullets_left), resM);
    checkOutput({name, ".score"}, int'(my_score), scoreM);
  endtask

  task automatic transfer();
    int mv;
    mv   = (3 - magM < resM) ? 3 - magM : resM;
    magM = magM + mv;
    resM = resM - mv;
  endtask

  task automatic waitHunt();
    int n = 0;
    while (!hunt_start && n < 200) begin
      tick(1);
      n++;
    end
    checkOutput("waitHunt", int'(hunt_start), 1);
  endtask

  task automatic fire(input string name, input int x, input int y, input int killMask);
    if (killMask != 0) begin
      pushExp(EV_KILL, packKill(killMask, scoreM + 1, magM - 1));
      pushExp(EV_DOG, 11);
      pushExp(EV_HUNT, 20);
    end
    applyStimulus(x, y, 1'b1, 1'b0);
    magM--;
    if (killMask != 0) scoreM++;
    checkAmmo(name);
    checkOutput({name, ".reloadChar"}, int'(show_reload_char), int'(magM == 0));
    if (killMask != 0) begin
      waitHunt();
    end else if (AUTO && magM == 0 && resM > 0) begin
      tick(4);
      transfer();
      checkAmmo({name, ".auto"});
    end else begin
      tick(1);
    end
  endtask

  task automatic reload(input string name);
    bit effective;
    effective = (magM < 3) && (resM > 0);
    applyStimulus(600, 600, 1'b0, 1'b1);
    if (effective) begin
      tick(3);
      checkOutput({name, ".pending"}, int'(bullets_in_magazine), magM);
      tick(1);
      transfer();
      checkAmmo({name, ".done"});
    end else begin
      tick(2);
      checkAmmo({name, ".ignored"});
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    game_enable  = 1'b0;
    mouse_xpos   = '0;
    mouse_ypos   = '0;
    left_mouse   = 1'b0;
    right_mouse  = 1'b0;
    target_xpos  = {12'd100, 12'd100};
    target_ypos  = {12'd100, 12'd100};
    target_alive = 2'b11;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    checkAmmo("reset");
    checkOutput("reset.hunt",   int'(hunt_start), 0);
    checkOutput("reset.over",   int'(game_over), 0);
    checkOutput("reset.killed", int'(target_killed), 0);
    checkOutput("reset.dog",    int'(dog_bird_enable), 0);
    checkOutput("reset.reloadChar", int'(show_reload_char), 0);

    $display("[TB] countdown with ignored clicks");
    pushExp(EV_HUNT, 41);
    game_enable = 1'b1;
    tick(3);
    applyStimulus(150, 130, 1'b1, 1'b0);
    tick(1);
    applyStimulus(150, 130, 1'b0, 1'b1);
    tick(1);
    applyStimulus(150, 130, 1'b1, 1'b0);
    checkAmmo("countdown");
    checkOutput("countdown.hunt", int'(hunt_start), 0);
    waitHunt();

    $display("[TB] overlapping targets, priority, alive mask and corner");
    fire("kill0", 150, 130, 1);
    target_alive = 2'b10;
    fire("corner", 196, 160, 2);
    target_alive = 2'b11;
    fire("missEdge", 197, 160, 0);
    reload("reload1");

    $display("[TB] draining ammunition");
    repeat (3) begin
      repeat (3) fire("miss", 500, 500, 0);
      reload("reloadN");
    end
    repeat (2) fire("miss", 500, 500, 0);
    reload("reloadPartial");
    repeat (2) fire("miss", 500, 500, 0);
    reload("reloadLast");
    reload("reloadEmptyReserve");
    repeat (2) fire("missFinal", 500, 500, 0);

    checkOutput("gameover.over", int'(game_over), 1);
    checkOutput("gameover.hunt", int'(hunt_start), 0);
    applyStimulus(150, 130, 1'b1, 1'b0);
    tick(1);
    checkOutput("gameover.clickMag", int'(bullets_in_magazine), 0);
    checkOutput("gameover.stays", int'(game_over), 1);

    game_enable = 1'b0;
    tick(1);
    magM = 3;
    resM = 15;
    scoreM = 0;
    checkAmmo("abort");
    checkOutput("abort.over", int'(game_over), 0);
    checkOutput("abort.hunt", int'(hunt_start), 0);

    tick(5);
    checkOutput("scoreboard.pending", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
